// File: rtl/hole_fall_detector.sv
// hole_fall_detector
//   Win/fail hole detector for the teeter board. One distance unit is shared
//   across all holes: the win hole and HOLE_NUM fail holes are scanned one per
//   cycle after a frame tick. A hit counts only once the ball has stayed in
//   the same hole for DWELL_FRAMES frames. After a hit the result is latched
//   and a FALL_FRAMES-tick fall window runs.
//
// Ports
//   i_clk, i_rst       clock, async active-low reset
//   is_game_playing    low = abort, clear results, back to IDLE
//   i_frame_tick       one pulse per frame, starts a scan from IDLE
//   i_bl_x/_y          ball centre
//   i_wh_pos_x/_y      win hole centre
//   i_fh_pos_x/_y      fail hole k centre at [10k+9:10k]
//   i_fh_en            per fail hole enable
//   o_win, o_fail      committed result (sticky until abort)
//   o_fail_each        one-hot committed fail hole
//   o_pos_fall_x/_y    committed hole centre, else SPRITE_BL_X/Y
//   o_falling          high during the fall window
//   o_fall_done        one-cycle pulse when the fall window ends
//   o_busy             high while scanning or evaluating

// Squared euclidean distance between two points, 10-bit unsigned coordinates.
module hole_dist (
   input  logic [9:0]  ax,
   input  logic [9:0]  ay,
   input  logic [9:0]  bx,
   input  logic [9:0]  by,
   output logic [20:0] dist2
);
   logic [9:0]  dx, dy;
   logic [19:0] sqx, sqy;

   // Absolute difference, so far-apart points never wrap to look close.
   assign dx    = (ax >= bx) ? (ax - bx) : (bx - ax);
   assign dy    = (ay >= by) ? (ay - by) : (by - ay);
   assign sqx   = {10'd0, dx} * {10'd0, dx};
   assign sqy   = {10'd0, dy} * {10'd0, dy};
   assign dist2 = {1'b0, sqx} + {1'b0, sqy};
endmodule

module hole_fall_detector #(
   parameter int RADIUS       = 16,
   parameter int HOLE_NUM     = 5,
   parameter int DWELL_FRAMES = 2,
   parameter int FALL_FRAMES  = 30,
   parameter int SPRITE_BL_X  = 0,
   parameter int SPRITE_BL_Y  = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   is_game_playing,
   input  logic                   i_frame_tick,
   input  logic [9:0]             i_bl_x,
   input  logic [9:0]             i_bl_y,
   input  logic [9:0]             i_wh_pos_x,
   input  logic [9:0]             i_wh_pos_y,
   input  logic [10*HOLE_NUM-1:0] i_fh_pos_x,
   input  logic [10*HOLE_NUM-1:0] i_fh_pos_y,
   input  logic [HOLE_NUM-1:0]    i_fh_en,
   output logic                   o_win,
   output logic                   o_fail,
   output logic [HOLE_NUM-1:0]    o_fail_each,
   output logic [9:0]             o_pos_fall_x,
   output logic [9:0]             o_pos_fall_y,
   output logic                   o_falling,
   output logic                   o_fall_done,
   output logic                   o_busy
);
   localparam int IW = $clog2(HOLE_NUM + 1);
   localparam int CW = $clog2(HOLE_NUM + 2);
   localparam int DW = $clog2(DWELL_FRAMES + 1);
   localparam int FW = $clog2(FALL_FRAMES + 1);
   localparam logic [20:0] R2     = 21'(RADIUS * RADIUS);
   localparam logic [9:0]  BL_X   = 10'(SPRITE_BL_X);
   localparam logic [9:0]  BL_Y   = 10'(SPRITE_BL_Y);

   typedef enum logic [2:0] {IDLE, SCAN, EVAL, FALL, DONE} state_t;

   state_t                state_q, state_n;
   logic [IW-1:0]         idx_q, idx_n;
   logic [9:0]            bx_q, bx_n, by_q, by_n;
   logic [HOLE_NUM:0]     hit_q, hit_n;
   logic [CW-1:0]         cand_q, cand_n;
   logic [DW-1:0]         dwell_q, dwell_n;
   logic [FW-1:0]         fcnt_q, fcnt_n;
   logic                  win_q, win_n, fail_q, fail_n;
   logic [HOLE_NUM-1:0]   each_q, each_n;
   logic [9:0]            px_q, px_n, py_q, py_n;
   logic                  falling_q, falling_n, done_q, done_n, busy_q, busy_n;

   // Hole table: entry 0 is the win hole, entry k+1 is fail hole k.
   logic [HOLE_NUM:0][9:0] hx_all, hy_all;
   logic [HOLE_NUM:0]      en_all;
   logic [20:0]            dist2;
   logic                   scan_hit;

   always_comb begin
      hx_all[0] = i_wh_pos_x;
      hy_all[0] = i_wh_pos_y;
      for (int k = 0; k < HOLE_NUM; k++) begin
         hx_all[k+1] = i_fh_pos_x[10*k +: 10];
         hy_all[k+1] = i_fh_pos_y[10*k +: 10];
      end
   end
   assign en_all = {i_fh_en, 1'b1};

   hole_dist u_dist (
      .ax    (bx_q),
      .ay    (by_q),
      .bx    (hx_all[idx_q]),
      .by    (hy_all[idx_q]),
      .dist2 (dist2)
   );

   assign scan_hit = (dist2 < R2) && en_all[idx_q];

   // Candidate selection: win beats any fail hole, lowest fail index wins.
   logic [HOLE_NUM-1:0] fh_hits, fail_oh;
   logic [CW-1:0]       fail_code, eval_cand;
   logic [9:0]          fail_px, fail_py;

   assign fh_hits = hit_q[HOLE_NUM:1];
   assign fail_oh = fh_hits & (~fh_hits + HOLE_NUM'(1));

   always_comb begin
      fail_code = '0;
      fail_px   = '0;
      fail_py   = '0;
      for (int k = HOLE_NUM - 1; k >= 0; k--)
         if (fh_hits[k]) fail_code = CW'(k + 2);
      for (int k = 0; k < HOLE_NUM; k++)
         if (fail_oh[k]) begin
            fail_px = fail_px | hx_all[k+1];
            fail_py = fail_py | hy_all[k+1];
         end
   end
   assign eval_cand = hit_q[0] ? CW'(1) : fail_code;

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      bx_n    = bx_q;
      by_n    = by_q;
      hit_n   = hit_q;
      cand_n  = cand_q;
      dwell_n = dwell_q;
      fcnt_n  = fcnt_q;
      win_n   = win_q;
      fail_n  = fail_q;
      each_n  = each_q;
      px_n    = px_q;
      py_n    = py_q;
      done_n  = 1'b0;

      case (state_q)
         IDLE: if (i_frame_tick) begin
            bx_n    = i_bl_x;
            by_n    = i_bl_y;
            idx_n   = '0;
            hit_n   = '0;
            state_n = SCAN;
         end
         SCAN: begin
            hit_n[idx_q] = scan_hit;
            if (idx_q == IW'(HOLE_NUM)) state_n = EVAL;
            else                        idx_n   = idx_q + IW'(1);
         end
         EVAL: begin
            cand_n = eval_cand;
            if (eval_cand == '0)
               dwell_n = '0;
            else if (eval_cand == cand_q)
               dwell_n = (dwell_q == DW'(DWELL_FRAMES)) ? dwell_q : dwell_q + DW'(1);
            else
               dwell_n = DW'(1);

            if (eval_cand != '0 && dwell_n == DW'(DWELL_FRAMES)) begin
               win_n   = hit_q[0];
               fail_n  = !hit_q[0];
               each_n  = hit_q[0] ? '0 : fail_oh;
               px_n    = hit_q[0] ? hx_all[0] : fail_px;
               py_n    = hit_q[0] ? hy_all[0] : fail_py;
               fcnt_n  = '0;
               state_n = FALL;
            end else begin
               state_n = IDLE;
            end
         end
         FALL: if (i_frame_tick) begin
            if (fcnt_q == FW'(FALL_FRAMES - 1)) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               fcnt_n = fcnt_q + FW'(1);
            end
         end
         DONE: ;
         default: state_n = IDLE;
      endcase

      // Abort wins over any tick or commit in the same cycle.
      if (!is_game_playing) begin
         state_n = IDLE;
         hit_n   = '0;
         cand_n  = '0;
         dwell_n = '0;
         fcnt_n  = '0;
         win_n   = 1'b0;
         fail_n  = 1'b0;
         each_n  = '0;
         px_n    = BL_X;
         py_n    = BL_Y;
         done_n  = 1'b0;
      end

      falling_n = (state_n == FALL);
      busy_n    = (state_n == SCAN) || (state_n == EVAL);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         bx_q      <= '0;
         by_q      <= '0;
         hit_q     <= '0;
         cand_q    <= '0;
         dwell_q   <= '0;
         fcnt_q    <= '0;
         win_q     <= 1'b0;
         fail_q    <= 1'b0;
         each_q    <= '0;
         px_q      <= BL_X;
         py_q      <= BL_Y;
         falling_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_n;
         idx_q     <= idx_n;
         bx_q      <= bx_n;
         by_q      <= by_n;
         hit_q     <= hit_n;
         cand_q    <= cand_n;
         dwell_q   <= dwell_n;
         fcnt_q    <= fcnt_n;
         win_q     <= win_n;
         fail_q    <= fail_n;
         each_q    <= each_n;
         px_q      <= px_n;
         py_q      <= py_n;
         falling_q <= falling_n;
         done_q    <= done_n;
         busy_q    <= busy_n;
      end
   end

   assign o_win        = win_q;
   assign o_fail       = fail_q;
   assign o_fail_each  = each_q;
   assign o_pos_fall_x = px_q;
   assign o_pos_fall_y = py_q;
   assign o_falling    = falling_q;
   assign o_fall_done  = done_q;
   assign o_busy       = busy_q;
endmodule

// File: tb/tb_hole_fall_detector.sv
// Directed bench for hole_fall_detector (RADIUS=16, HOLE_NUM=5,
// DWELL_FRAMES=2, FALL_FRAMES=3). A table of single-scenario vectors plus
// hand-written sequences for latency, dwell streaks, abort and async reset.
module tb_hole_fall_detector;
   localparam int HN = 5;

   logic          clk = 1'b0;
   logic          rst, gp, tick;
   logic [9:0]    blx, bly, whx, why;
   logic [10*HN-1:0] fhx, fhy;
   logic [HN-1:0] fen;
   logic          win, fail, falling, fdone, busy;
   logic [HN-1:0] each;
   logic [9:0]    px, py;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hole_fall_detector #(
      .RADIUS(16), .HOLE_NUM(HN), .DWELL_FRAMES(2), .FALL_FRAMES(3),
      .SPRITE_BL_X(0), .SPRITE_BL_Y(0)
   ) dut (
      .i_clk(clk), .i_rst(rst), .is_game_playing(gp), .i_frame_tick(tick),
      .i_bl_x(blx), .i_bl_y(bly), .i_wh_pos_x(whx), .i_wh_pos_y(why),
      .i_fh_pos_x(fhx), .i_fh_pos_y(fhy), .i_fh_en(fen),
      .o_win(win), .o_fail(fail), .o_fail_each(each),
      .o_pos_fall_x(px), .o_pos_fall_y(py),
      .o_falling(falling), .o_fall_done(fdone), .o_busy(busy)
   );

   typedef struct {
      string         nm;
      logic [9:0]    bx, by, wx, wy;
      logic [10*HN-1:0] fx, fy;
      logic [HN-1:0] en;
      int            nt;
      logic          ew, ef;
      logic [HN-1:0] ee;
      logic [9:0]    ex, ey;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Fail hole k parked at (50+100k, 900), win hole at (500,500).
   function automatic vec_t dflt(input string nm, input int bx, input int by);
      vec_t v;
      v.nm = nm; v.bx = 10'(bx); v.by = 10'(by);
      v.wx = 10'd500; v.wy = 10'd500;
      for (int k = 0; k < HN; k++) begin
         v.fx[10*k +: 10] = 10'(50 + 100*k);
         v.fy[10*k +: 10] = 10'd900;
      end
      v.en = '1; v.nt = 2;
      v.ew = 1'b0; v.ef = 1'b0; v.ee = '0; v.ex = '0; v.ey = '0;
      return v;
   endfunction

   function automatic vec_t put_fh(input vec_t v, input int k, input int x, input int y);
      vec_t r = v;
      r.fx[10*k +: 10] = 10'(x);
      r.fy[10*k +: 10] = 10'(y);
      return r;
   endfunction

   function automatic vec_t expect_hit(input vec_t v, input logic w, input logic [HN-1:0] e,
                                       input int x, input int y);
      vec_t r = v;
      r.ew = w; r.ef = !w; r.ee = e; r.ex = 10'(x); r.ey = 10'(y);
      return r;
   endfunction

   task automatic abort_cyc();
      gp = 1'b0;
      @(negedge clk);
      gp = 1'b1;
   endtask

   // One frame: ball present only at the tick; moved far away during the scan
   // so a live (non-snapshotted) ball would miss.
   task automatic tick_frame(input logic [9:0] bx, input logic [9:0] by);
      blx = bx; bly = by; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0; blx = 10'd1023; bly = 10'd1023;
      repeat (9) @(negedge clk);
   endtask

   task automatic set_defaults();
      vec_t d = dflt("d", 0, 0);
      whx = d.wx; why = d.wy; fhx = d.fx; fhy = d.fy; fen = d.en;
   endtask

   task automatic run_vec(input vec_t v);
      abort_cyc();
      whx = v.wx; why = v.wy; fhx = v.fx; fhy = v.fy; fen = v.en;
      for (int n = 0; n < v.nt; n++) tick_frame(v.bx, v.by);
      chk({v.nm, ".win"},     32'(win),     32'(v.ew));
      chk({v.nm, ".fail"},    32'(fail),    32'(v.ef));
      chk({v.nm, ".each"},    32'(each),    32'(v.ee));
      chk({v.nm, ".px"},      32'(px),      32'(v.ex));
      chk({v.nm, ".py"},      32'(py),      32'(v.ey));
      chk({v.nm, ".falling"}, 32'(falling), 32'(v.ew | v.ef));
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      rst = 1'b0; gp = 1'b0; tick = 1'b0; blx = '0; bly = '0;
      set_defaults();

      // Table of single-scenario vectors
      v = dflt("win_basic", 100, 100); v.wx = 10'd110; v.wy = 10'd110;
      tbl.push_back(expect_hit(v, 1'b1, 5'b00000, 110, 110));
      v = put_fh(dflt("fh3_in", 200, 200), 3, 200, 215);
      tbl.push_back(expect_hit(v, 1'b0, 5'b01000, 200, 215));
      tbl.push_back(put_fh(dflt("fh3_edge", 200, 200), 3, 200, 216));
      v = put_fh(dflt("win_prio", 300, 300), 1, 300, 305); v.wx = 10'd305; v.wy = 10'd300;
      tbl.push_back(expect_hit(v, 1'b1, 5'b00000, 305, 300));
      v = dflt("en_off", 50, 900); v.en = 5'b11110; v.nt = 4;
      tbl.push_back(v);
      tbl.push_back(put_fh(dflt("no_wrap", 0, 0), 2, 1023, 0));
      v = dflt("one_tick", 450, 900); v.nt = 1;
      tbl.push_back(v);
      v = put_fh(put_fh(dflt("low_fail", 400, 400), 1, 400, 410), 3, 410, 400);
      tbl.push_back(expect_hit(v, 1'b0, 5'b00010, 400, 410));
      v = put_fh(dflt("diag_in", 600, 100), 4, 612, 110);
      tbl.push_back(expect_hit(v, 1'b0, 5'b10000, 612, 110));
      tbl.push_back(put_fh(dflt("diag_out", 600, 100), 4, 612, 111));
      v = put_fh(dflt("corner", 0, 1023), 0, 0, 1008);
      tbl.push_back(expect_hit(v, 1'b0, 5'b00001, 0, 1008));

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.win", 32'(win), 0);
      chk("rst.fail", 32'(fail), 0);
      chk("rst.each", 32'(each), 0);
      chk("rst.pos", {12'd0, px, py}, 0);
      chk("rst.flags", {29'd0, falling, fdone, busy}, 0);
      rst = 1'b1; gp = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) run_vec(tbl[i]);

      // Commit latency and fall window
      abort_cyc(); set_defaults(); whx = 10'd110; why = 10'd110;
      tick_frame(10'd100, 10'd100);
      blx = 10'd100; bly = 10'd100; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0; blx = 10'd1023; bly = 10'd1023;
      repeat (6) @(negedge clk);
      chk("lat.win_e6", 32'(win), 0);
      chk("lat.busy_e6", 32'(busy), 1);
      @(negedge clk);
      chk("lat.win_e7", 32'(win), 1);
      chk("lat.pos_e7", {12'd0, px, py}, {12'd0, 10'd110, 10'd110});
      chk("lat.busy_e7", 32'(busy), 0);
      for (int t = 1; t <= 2; t++) begin
         tick = 1'b1; @(negedge clk); tick = 1'b0;
         repeat (3) @(negedge clk);
         chk("fall.mid_falling", 32'(falling), 1);
         chk("fall.mid_done", 32'(fdone), 0);
      end
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      chk("fall.done_pulse", 32'(fdone), 1);
      chk("fall.done_falling", 32'(falling), 0);
      chk("fall.done_win", 32'(win), 1);
      @(negedge clk);
      chk("fall.done_once", 32'(fdone), 0);
      tick_frame(10'd100, 10'd100);
      chk("done.tick_ign_done", 32'(fdone), 0);
      chk("done.tick_ign_busy", 32'(busy), 0);
      chk("done.hold_win", 32'(win), 1);

      // Dwell streak broken by a miss
      abort_cyc(); set_defaults();
      tick_frame(10'd50, 10'd900);
      tick_frame(10'd1000, 10'd100);
      tick_frame(10'd50, 10'd900);
      chk("streak.after3", 32'(fail), 0);
      tick_frame(10'd50, 10'd900);
      chk("streak.after4", 32'(fail), 1);
      chk("streak.each", 32'(each), 32'(5'b00001));

      // Abort during FALL
      gp = 1'b0;
      @(negedge clk);
      chk("abort.win_fail", {30'd0, win, fail}, 0);
      chk("abort.each", 32'(each), 0);
      chk("abort.pos", {12'd0, px, py}, 0);
      chk("abort.falling", 32'(falling), 0);
      gp = 1'b1;

      // Candidate change restarts the streak
      tick_frame(10'd50, 10'd900);
      tick_frame(10'd250, 10'd900);
      chk("cand_chg.t2", 32'(fail), 0);
      tick_frame(10'd250, 10'd900);
      chk("cand_chg.t3", 32'(fail), 1);
      chk("cand_chg.each", 32'(each), 32'(5'b00100));
      chk("cand_chg.px", 32'(px), 250);

      // Async reset with committed outputs, no clock edge
      rst = 1'b0;
      #1;
      chk("arst.fail", 32'(fail), 0);
      chk("arst.each", 32'(each), 0);
      chk("arst.pos", {12'd0, px, py}, 0);
      chk("arst.falling", 32'(falling), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Async reset mid-scan
      blx = 10'd50; bly = 10'd900; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("scan.busy", 32'(busy), 1);
      rst = 1'b0;
      #1;
      chk("scan_rst.busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("scan_rst.idle_busy", 32'(busy), 0);
      chk("scan_rst.fail", 32'(fail), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
